// File: rtl/sdr_16_rd_capture.sv
// Read-data capture for the SDR 16-bit controller. A read tag rides a CAS-latency
// delay line, two DQ beats are paired into one 32-bit egress FIFO write, and errors are sticky.
module sdr_16_rd_capture #(
    parameter int cl     = 2,
    parameter int in_reg = 1
) (
    input  logic        sdram_clk,
    input  logic        sdram_rst,
    input  logic        cmd_read,
    input  logic [0:15] fifo_sel_i,
    input  logic [1:0]  fifo_sel_domain_i,
    input  logic [15:0] dq_i,
    input  logic        fifo_full,
    output logic        fifo_wr,
    output logic [31:0] fifo_dat_o,
    output logic [0:15] fifo_sel_o,
    output logic [1:0]  fifo_sel_domain_o,
    output logic        busy,
    output logic        ovf_err,
    output logic        seq_err,
    input  logic        err_clr
);

    localparam int d = cl + in_reg;

    typedef struct packed {
        logic        valid;
        logic [0:15] sel;
        logic [1:0]  domain;
    } tag_t;

    // tag_line[k] holds the tag of the read issued k+1 cycles ago.
    tag_t        tag_line [0:d];
    logic        cmd_prev;
    logic        accept;
    logic        held_valid;
    logic [15:0] beat0;
    logic [0:15] held_sel;
    logic [1:0]  held_domain;

    // Handshake: a read is taken only when cmd_read was low the cycle before;
    // there is no ready toward the controller, so violations are only flagged.
    assign accept = cmd_read & ~cmd_prev;

    always_ff @(posedge sdram_clk) begin
        if (sdram_rst) begin
            cmd_prev <= 1'b0;
            for (int i = 0; i <= d; i++) begin
                tag_line[i] <= '0;
            end
        end else begin
            cmd_prev    <= cmd_read;
            tag_line[0] <= '{valid: accept, sel: fifo_sel_i, domain: fifo_sel_domain_i};
            for (int i = 1; i <= d; i++) begin
                tag_line[i] <= tag_line[i-1];
            end
        end
    end

    // Beat0 arrives while the tag sits in tag_line[d-1]; beat1 one cycle later.
    always_ff @(posedge sdram_clk) begin
        if (sdram_rst) begin
            held_valid  <= 1'b0;
            beat0       <= '0;
            held_sel    <= '0;
            held_domain <= '0;
        end else begin
            held_valid <= tag_line[d-1].valid;
            if (tag_line[d-1].valid) begin
                beat0       <= dq_i;
                held_sel    <= tag_line[d-1].sel;
                held_domain <= tag_line[d-1].domain;
            end
        end
    end

    always_ff @(posedge sdram_clk) begin
        if (sdram_rst) begin
            fifo_wr           <= 1'b0;
            fifo_dat_o        <= '0;
            fifo_sel_o        <= '0;
            fifo_sel_domain_o <= '0;
        end else begin
            fifo_wr <= held_valid;
            if (held_valid) begin
                fifo_dat_o        <= {beat0, dq_i};
                fifo_sel_o        <= held_sel;
                fifo_sel_domain_o <= held_domain;
            end
        end
    end

    // A new error in the same cycle as err_clr keeps the bit set.
    always_ff @(posedge sdram_clk) begin
        if (sdram_rst) begin
            ovf_err <= 1'b0;
            seq_err <= 1'b0;
        end else begin
            ovf_err <= (fifo_wr & fifo_full) | (ovf_err & ~err_clr);
            seq_err <= (cmd_read & cmd_prev) | (seq_err & ~err_clr);
        end
    end

    always_comb begin
        busy = held_valid | fifo_wr;
        for (int i = 0; i <= d; i++) begin
            busy = busy | tag_line[i].valid;
        end
    end

endmodule
